// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: issues one imem request at a time from the current PC,
// queues {pc, instr} pairs in a small FIFO and hands them to decode via valid/ready.
module fetch_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_addr,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             flush,
  output logic             pc_advance,
  output logic             ifid_valid,
  output logic [WIDTH-1:0] ifid_instr,
  output logic [WIDTH-1:0] ifid_pc,
  input  logic             id_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] SETTLE = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] instr;
  } fb_entry_t;

  logic [1:0]            state;
  fb_entry_t [DEPTH-1:0] fifo;
  logic [AW-1:0]         rptr, wptr;
  logic [AW:0]           count;
  logic                  full, push, pop;

  assign full       = (count == FULL);
  assign push       = (state == REQ) && imem_ack && !flush;
  assign pop        = (count != '0) && id_ready;
  assign ifid_valid = (count != '0);
  assign ifid_pc    = fifo[rptr].pc;
  assign ifid_instr = fifo[rptr].instr;

  // Fetch control: one outstanding request; issue only with a free slot so a push never overflows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      pc_advance <= 1'b0;
    end else begin
      pc_advance <= 1'b0;
      case (state)
        IDLE: begin
          if (!full && !flush) begin
            imem_addr <= fetch_addr;
            imem_req  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            if (!flush) begin
              pc_advance <= 1'b1;
              state      <= SETTLE;
            end else begin
              state <= IDLE;
            end
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        // Memory still owes us a beat; swallow it before fetching the redirected PC.
        DRAIN: begin
          if (imem_ack) begin
            imem_req <= 1'b0;
            state    <= IDLE;
          end
        end
        SETTLE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO: flush wins over a same-cycle push or pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo  <= '0;
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[wptr] <= '{pc: imem_addr, instr: imem_rdata};
        wptr       <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: behavioural PC register and memory, plus a scoreboard
// of expected FIFO contents filled at each accepted ack and checked against ifid_*.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        flush = 1'b0;
  logic        pc_advance;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        id_ready = 1'b0;

  fetch_buffer #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .fetch_addr(fetch_addr),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .flush(flush), .pc_advance(pc_advance),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .id_ready(id_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // PC register: reset value, redirect on flush, step on pc_advance.
  logic [31:0] pc_init = '0;
  logic [31:0] redirect_pc = '0;
  always @(posedge clk or posedge rst) begin
    if (rst)             fetch_addr <= pc_init;
    else if (flush)      fetch_addr <= redirect_pc;
    else if (pc_advance) fetch_addr <= fetch_addr + 32'd1;
  end

  // Memory: acks in the lat-th cycle that req is held; address must not move meanwhile.
  int          lat  = 1;
  int          hold = 0;
  logic [31:0] held_addr;
  always @(posedge clk) begin
    #2;
    if (rst || !imem_req) begin
      hold       = 0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
    end else begin
      if (hold == 0) held_addr = imem_addr;
      else           chk("addr_hold", imem_addr, held_addr);
      hold++;
      imem_ack   = (hold >= lat);
      imem_rdata = imem_ack ? 32'hA000_0000 + imem_addr : '0;
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        q[$];
  logic [31:0] got_pc[$];
  logic        discard = 1'b0;
  logic        exp_adv = 1'b0;
  int          adv_cnt = 0;

  always @(negedge clk) begin
    logic do_push;
    if (rst) begin
      q.delete();
      discard = 1'b0;
      exp_adv = 1'b0;
      chk("rst_req",   imem_req,   0);
      chk("rst_addr",  imem_addr,  0);
      chk("rst_adv",   pc_advance, 0);
      chk("rst_valid", ifid_valid, 0);
      chk("rst_pc",    ifid_pc,    0);
      chk("rst_instr", ifid_instr, 0);
    end else begin
      chk("adv", pc_advance, exp_adv);
      if (pc_advance) adv_cnt++;
      chk("valid", ifid_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("head_pc",    ifid_pc,    q[0].pc);
        chk("head_instr", ifid_instr, q[0].instr);
      end
      if (ifid_valid && id_ready) got_pc.push_back(ifid_pc);
      do_push = imem_req && imem_ack && !flush && !discard;
      if (imem_req && imem_ack)  discard = 1'b0;
      else if (imem_req && flush) discard = 1'b1;
      exp_adv = do_push;
      if (flush) q.delete();
      else begin
        if (q.size() != 0 && id_ready) void'(q.pop_front());
        if (do_push) q.push_back('{pc: fetch_addr, instr: 32'hA000_0000 + fetch_addr});
      end
    end
  end

  task automatic do_reset(input logic [31:0] pcv);
    pc_init  = pcv;
    rst      = 1'b1;
    flush    = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !imem_req; i++) begin
      @(posedge clk); #1;
    end
    chk(tag, imem_req, 1);
  endtask

  task automatic wait_ack(input string tag);
    for (int i = 0; i < 20 && !imem_ack; i++) begin
      @(posedge clk); #3;
    end
    chk(tag, imem_ack, 1);
  endtask

  task automatic wait_adv(input string tag, input int n);
    for (int i = 0; i < 40 && adv_cnt < n; i++) begin
      @(negedge clk); #1;
    end
    chk(tag, adv_cnt >= n, 1);
  endtask

  initial begin
    // steady fetch, decode always ready
    lat = 1;
    do_reset(32'h0);
    adv_cnt = 0;
    got_pc.delete();
    id_ready = 1'b1;
    for (int i = 0; i < 40 && got_pc.size() < 3; i++) begin
      @(negedge clk); #1;
    end
    chk("st_cnt", got_pc.size(), 3);
    if (got_pc.size() >= 3) begin
      chk("st_pc0", got_pc[0], 0);
      chk("st_pc1", got_pc[1], 1);
      chk("st_pc2", got_pc[2], 2);
    end
    chk("st_adv", adv_cnt, 3);

    // backpressure: FIFO fills, no further requests
    do_reset(32'h0);
    adv_cnt = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("bp_adv", adv_cnt, 2);
    chk("bp_head", ifid_pc, 0);
    for (int i = 0; i < 4; i++) begin
      chk("bp_noreq", imem_req, 0);
      @(posedge clk); #1;
    end
    id_ready = 1'b1;
    @(posedge clk); #1;
    id_ready = 1'b0;
    chk("bp_next_head", ifid_pc, 1);
    wait_req("bp_req");
    chk("bp_addr", imem_addr, 2);

    // memory wait states
    do_reset(32'h5);
    lat = 4;
    adv_cnt = 0;
    id_ready = 1'b1;
    wait_ack("ws_ack");
    chk("ws_hold", hold, 4);
    chk("ws_addr", imem_addr, 5);
    repeat (2) @(posedge clk);
    #1;
    chk("ws_adv", adv_cnt, 1);

    // flush while a request is outstanding
    do_reset(32'h10);
    lat = 1;
    adv_cnt = 0;
    wait_adv("fl_first", 1);
    lat = 3;
    wait_req("fl_req");
    redirect_pc = 32'h40;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_valid", ifid_valid, 0);
    chk("fl_req_held", imem_req, 1);
    for (int i = 0; i < 10 && imem_req; i++) begin
      @(posedge clk); #1;
    end
    chk("fl_req_drop", imem_req, 0);
    chk("fl_adv", adv_cnt, 1);
    wait_req("fl_req2");
    chk("fl_redirect", imem_addr, 32'h40);

    // flush coinciding with ack and with pop
    do_reset(32'h200);
    lat = 2;
    adv_cnt = 0;
    wait_adv("fa_first", 1);
    wait_ack("fa_ack");
    redirect_pc = 32'h300;
    flush    = 1'b1;
    id_ready = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    id_ready = 1'b0;
    chk("fa_valid", ifid_valid, 0);
    chk("fa_adv0", pc_advance, 0);
    @(posedge clk); #1;
    chk("fa_adv1", pc_advance, 0);
    chk("fa_adv_cnt", adv_cnt, 1);

    // async reset in the middle of a request
    do_reset(32'h20);
    lat = 1;
    adv_cnt = 0;
    wait_adv("ar_first", 1);
    lat = 4;
    wait_req("ar_req");
    chk("ar_valid_pre", ifid_valid, 1);
    #2;
    pc_init = 32'h80;
    rst = 1'b1;
    #1;
    chk("ar_req", imem_req, 0);
    chk("ar_valid", ifid_valid, 0);
    chk("ar_adv", pc_advance, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_req("ar_req2");
    chk("ar_restart", imem_addr, 32'h80);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, runs a req/ack transaction with instruction memory, and queues {pc, instruction} pairs in a small FIFO.
- The FIFO feeds the IF/ID interface of decode through a valid/ready handshake.
- Pulses pc_advance so the next-PC logic steps the PC; accepts flush on branch/jump redirect.

Parameters:
- WIDTH, 32, PC and instruction width.
- DEPTH, 2, FIFO entries (power of 2, at least 2).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_addr  in  WIDTH  current PC value. Stable by the rising edge after pc_advance.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  WIDTH  request address; registered at issue.
- imem_ack  in  1  memory has returned data this cycle.
- imem_rdata  in  WIDTH  instruction word; valid when imem_ack=1.
- flush  in  1  redirect; discard all buffered and in-flight fetches.
- pc_advance  out  1  one-cycle pulse telling next-PC logic to step the PC.
- ifid_valid  out  1  FIFO head holds a valid instruction.
- ifid_instr  out  WIDTH  instruction at FIFO head.
- ifid_pc  out  WIDTH  PC of instruction at FIFO head.
- id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, count=0, read/write pointers=0.
  - imem_req=0, imem_addr=0, pc_advance=0.
  - ifid_valid=0, ifid_instr=0, ifid_pc=0; all FIFO storage cleared.
  - Reset mid-transaction abandons the request. Memory must tolerate req dropping without ack.
- States: IDLE, REQ, SETTLE, DRAIN.
- IDLE:
  - If count<DEPTH and flush=0: imem_addr<=fetch_addr, imem_req<=1, go REQ.
  - Else stay IDLE.
- REQ:
  - imem_req=1 and imem_addr held constant until ack.
  - On imem_ack with flush=0: push {imem_addr, imem_rdata}, imem_req<=0, pc_advance<=1 for exactly one cycle, go SETTLE.
  - On imem_ack with flush=1: discard data, no push, no pc_advance, imem_req<=0, go IDLE.
  - On flush=1 with no ack: go DRAIN; req and address stay held.
- DRAIN:
  - imem_req stays 1 until imem_ack, then data is discarded and imem_req<=0, go IDLE.
  - flush during DRAIN has no further effect.
- SETTLE:
  - One-cycle bubble while the PC register loads the stepped value; always go IDLE next.
  - flush here clears the FIFO only.
- Request issue guard:
  - At most one outstanding request.
  - A new request issues only when count<DEPTH, so a push can never overflow.
- FIFO:
  - ifid_valid = (count!=0).
  - ifid_instr and ifid_pc come from the head entry and are stable while ifid_valid=1 and id_ready=0.
  - Pop occurs when ifid_valid & id_ready.
  - Push and pop in the same cycle leave count unchanged; the pointers wrap modulo DEPTH.
  - When empty, id_ready is ignored and there is no underflow.
- flush:
  - Next edge sets count=0 and pointers=0, so ifid_valid=0 the following cycle.
  - flush takes priority over a same-cycle push or pop.
- pc_advance is never asserted for a discarded fetch. Exactly one pulse per pushed instruction.
- Latency:
  - With ack 1 cycle after req, flush=0, and FIFO not full, throughput is 1 instruction per 3 cycles (IDLE→REQ→SETTLE).
  - Instruction is visible on ifid_* the cycle after ack.

Test Plan:
- Reset then steady fetch: fetch_addr steps 0,1,2 after each pc_advance; memory acks after 1 cycle with 0xA0000000+addr; id_ready=1 → decode receives (pc,instr) (0,0xA0000000),(1,0xA0000001),(2,0xA0000002) in order; exactly 3 pc_advance pulses.
- Backpressure: id_ready=0 → after 2 pushes count=2, imem_req stays 0, head holds pc=0 stable; raise id_ready for one cycle → pc=0 popped, next request issues with fetch_addr=2.
- Memory wait states: ack delayed 4 cycles → imem_req and imem_addr=5 constant for all 4 cycles; single push and single pc_advance.
- Flush mid-request: flush while in REQ (ack 2 cycles later) → FIFO empties next cycle, req held until ack, data discarded, no pc_advance; next fetch uses the redirected fetch_addr=0x40.
- Simultaneous flush+ack and flush+pop: no push, no pop effect, count=0, pc_advance stays 0.
- Async reset mid-REQ: assert rst between edges → imem_req, ifid_valid, pc_advance drop to 0 immediately; after release, fetch restarts from fetch_addr.
